// File: rtl/parser_collector_pkg.sv
// Shared definitions for the parser result collector: default sizes, FSM state
// encoding and a one-hot check helper.
package parser_collector_pkg;

    localparam int unsigned NumParserDef = 6;
    localparam int unsigned ResWDef      = 64;
    localparam int unsigned OrderAwDef   = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StStream = 2'd2
    } state_e;

    function automatic logic is_onehot(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, v[i]};
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/parser_collector_order_fifo.sv
// Synchronous order FIFO holding one-hot parser grants; registered head word
// with write bypass so the head is valid the cycle after any push or pop.
module parser_collector_order_fifo #(
    parameter int unsigned W  = 6,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic [AW:0]   count_o
);

    localparam int unsigned Depth = 1 << AW;

    logic [W-1:0]  mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          do_wr, do_rd;

    always_comb begin
        do_wr    = wr_en_i && (count_q != (AW+1)'(Depth));
        do_rd    = rd_en_i && (count_q != '0);
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - (AW+1)'(1);
        end
        // Bypass covers a push into an empty FIFO landing at the new head slot.
        if (do_wr && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = wr_data_i;
        end else begin
            rd_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign count_o   = count_q;

endmodule

// File: rtl/parser_collector.sv
// Reorders parser results into dispatch order, one slice at a time.
// Optional COLLECTOR_STATS_EN adds slice_cnt / stall_cnt counters.
module parser_collector
    import parser_collector_pkg::*;
#(
    parameter int unsigned NUM_PARSER = NumParserDef,
    parameter int unsigned RES_W      = ResWDef,
    parameter int unsigned ORDER_AW   = OrderAwDef
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        disp_valid,
    input  logic [NUM_PARSER-1:0]       disp_grant,
    output logic                        order_full,
    input  logic [NUM_PARSER-1:0]       res_valid,
    input  logic [NUM_PARSER*RES_W-1:0] res_data,
    input  logic [NUM_PARSER-1:0]       res_last,
    output logic [NUM_PARSER-1:0]       res_rdreq,
    output logic                        out_valid,
    output logic [RES_W-1:0]            out_data,
    output logic                        out_last,
    input  logic                        out_ready,
`ifdef COLLECTOR_STATS_EN
    output logic [31:0]                 slice_cnt,
    output logic [31:0]                 stall_cnt,
`endif
    output logic                        err_onehot,
    output logic                        err_overflow
);

    localparam int unsigned Depth = 1 << ORDER_AW;
    localparam int unsigned CntW  = ORDER_AW + 1;

    state_e                state_q, state_d;
    logic [NUM_PARSER-1:0] head_q, head_d;
    logic                  out_valid_q, out_valid_d;
    logic [RES_W-1:0]      out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  order_full_q, order_full_d;
    logic                  err_onehot_q, err_onehot_d;
    logic                  err_overflow_q, err_overflow_d;

    logic [CntW-1:0]       fifo_count, count_nxt;
    logic [NUM_PARSER-1:0] fifo_head;
    logic                  fifo_full, fifo_wr, fifo_rd, grant_ok;
    logic                  pop, sel_last;
    logic [RES_W-1:0]      sel_data;

    parser_collector_order_fifo #(
        .W  (NUM_PARSER),
        .AW (ORDER_AW)
    ) u_order_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (fifo_wr),
        .wr_data_i (disp_grant),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_head),
        .count_o   (fifo_count)
    );

    always_comb begin
        grant_ok  = is_onehot(32'(disp_grant));
        fifo_full = (fifo_count == CntW'(Depth));
        fifo_wr   = disp_valid && grant_ok && !fifo_full;
    end

    // Pop only the head parser, and only when the output register can take a word.
    always_comb begin
        res_rdreq = '0;
        if (rst_n && (state_q == StStream) && (!out_valid_q || out_ready)) begin
            res_rdreq = head_q & res_valid;
        end
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < int'(NUM_PARSER); i++) begin
            if (head_q[i]) begin
                sel_data = sel_data | res_data[i*RES_W +: RES_W];
                sel_last = sel_last | res_last[i];
            end
        end
        pop     = |res_rdreq;
        fifo_rd = pop && sel_last;
    end

    always_comb begin
        count_nxt = fifo_count;
        if (fifo_wr && !fifo_rd) begin
            count_nxt = fifo_count + CntW'(1);
        end else if (!fifo_wr && fifo_rd) begin
            count_nxt = fifo_count - CntW'(1);
        end
    end

    always_comb begin
        state_d        = state_q;
        head_d         = head_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_last_d     = out_last_q;
        order_full_d   = (count_nxt >= CntW'(Depth - 2));
        err_onehot_d   = err_onehot_q | (disp_valid & ~grant_ok);
        err_overflow_d = err_overflow_q | (disp_valid & grant_ok & fifo_full);

        unique case (state_q)
            StIdle: begin
                if (fifo_count != '0) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                head_d  = fifo_head;
                state_d = StStream;
            end
            StStream: begin
                if (fifo_rd) begin
                    state_d = (fifo_count > CntW'(1)) ? StFetch : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            head_q         <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_last_q     <= 1'b0;
            order_full_q   <= 1'b0;
            err_onehot_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_last_q     <= out_last_d;
            order_full_q   <= order_full_d;
            err_onehot_q   <= err_onehot_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign order_full   = order_full_q;
    assign err_onehot   = err_onehot_q;
    assign err_overflow = err_overflow_q;

`ifdef COLLECTOR_STATS_EN
    logic [31:0] slice_cnt_q, slice_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        slice_cnt_d = slice_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && out_ready && out_last_q) begin
            slice_cnt_d = slice_cnt_q + 32'd1;
        end
        if (out_valid_q && !out_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slice_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            slice_cnt_q <= slice_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign slice_cnt = slice_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
